// File: rtl/mips_cpu_bus_bridge.sv
`default_nettype none
// ============================================================================
// Module      : mips_cpu_bus_bridge
// Description : Serialises a Harvard core's instruction fetch and optional
//               data access onto one Avalon-MM style bus with waitrequest,
//               and pulses the core clk_enable once per completed sequence.
// Revision    : 1.0 - initial release
// ============================================================================
module mips_cpu_bus_bridge #(
  parameter int unsigned MAX_WAIT = 0
) (
  input  logic        clk,
  input  logic        reset,
  output logic        cpu_clk_enable,
  input  logic        cpu_active,
  input  logic [31:0] cpu_instr_address,
  output logic [31:0] cpu_instr_readdata,
  input  logic [31:0] cpu_data_address,
  input  logic        cpu_data_read,
  input  logic        cpu_data_write,
  input  logic [3:0]  cpu_data_byteenable,
  input  logic [31:0] cpu_data_writedata,
  output logic [31:0] cpu_data_readdata,
  output logic [31:0] avm_address,
  output logic        avm_read,
  output logic        avm_write,
  output logic [3:0]  avm_byteenable,
  output logic [31:0] avm_writedata,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  output logic        bus_error
);

  localparam logic [31:0] C_MAX_WAIT = 32'(MAX_WAIT);

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    DATA   = 2'd1,
    STEP   = 2'd2,
    HALTED = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [31:0] r_wait_cnt;
  logic [31:0] w_wait_inc;
  logic [31:0] r_instr_readdata;
  logic [31:0] r_data_readdata;
  logic        r_bus_error;
  logic        w_strobe;
  logic        w_done;
  logic        w_timeout;
  logic        w_data_req;

  assign cpu_instr_readdata = r_instr_readdata;
  assign cpu_data_readdata  = r_data_readdata;
  assign bus_error          = r_bus_error;

  // Bus strobes are decoded from the registered state and the core's live
  // (stable) request lines so the first bus cycle of a sequence starts right
  // after the stepping edge; reset gates everything off immediately.
  always_comb begin
    w_state_next   = r_state;
    cpu_clk_enable = 1'b0;
    avm_read       = 1'b0;
    avm_write      = 1'b0;
    avm_address    = 32'h0;
    avm_byteenable = 4'h0;
    avm_writedata  = 32'h0;
    w_data_req     = cpu_data_read | cpu_data_write;

    if (reset) begin
      case (r_state)
        FETCH: begin
          if (cpu_active) begin
            avm_read       = 1'b1;
            avm_address    = cpu_instr_address;
            avm_byteenable = 4'hF;
          end
        end
        DATA: begin
          if (cpu_data_write) begin
            avm_write      = 1'b1;
            avm_address    = cpu_data_address;
            avm_byteenable = cpu_data_byteenable;
            avm_writedata  = cpu_data_writedata;
          end else if (cpu_data_read) begin
            avm_read       = 1'b1;
            avm_address    = cpu_data_address;
            avm_byteenable = 4'hF;
          end
        end
        STEP:    cpu_clk_enable = 1'b1;
        default: ;
      endcase
    end

    w_strobe   = avm_read | avm_write;
    w_done     = w_strobe & ~avm_waitrequest;
    w_wait_inc = (r_wait_cnt == 32'hFFFF_FFFF) ? r_wait_cnt : r_wait_cnt + 32'd1;
    w_timeout  = (C_MAX_WAIT != 32'd0) && w_strobe && avm_waitrequest &&
                 (w_wait_inc == C_MAX_WAIT);

    case (r_state)
      FETCH: begin
        if (!cpu_active) begin
          w_state_next = HALTED;
        end else if (w_timeout) begin
          w_state_next = HALTED;
        end else if (w_done) begin
          w_state_next = w_data_req ? DATA : STEP;
        end
      end
      DATA: begin
        // A vanished request cannot complete; step rather than hang.
        if (!w_data_req) begin
          w_state_next = STEP;
        end else if (w_timeout) begin
          w_state_next = HALTED;
        end else if (w_done) begin
          w_state_next = STEP;
        end
      end
      STEP:    w_state_next = FETCH;
      default: w_state_next = HALTED;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= FETCH;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Consecutive-stall counter: counts stalled strobe cycles, clears otherwise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wait_cnt <= 32'h0;
    end else if (w_strobe && avm_waitrequest) begin
      r_wait_cnt <= w_wait_inc;
    end else begin
      r_wait_cnt <= 32'h0;
    end
  end

  // Latch returned words for the core and keep the timeout flag sticky.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_instr_readdata <= 32'h0;
      r_data_readdata  <= 32'h0;
      r_bus_error      <= 1'b0;
    end else begin
      if (w_done && (r_state == FETCH)) begin
        r_instr_readdata <= avm_readdata;
      end
      if (w_done && (r_state == DATA) && avm_read) begin
        r_data_readdata <= avm_readdata;
      end
      if (w_timeout) begin
        r_bus_error <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mips_cpu_bus_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_mips_cpu_bus_bridge
// Description : Self-checking bench for mips_cpu_bus_bridge: directed
//               scenarios plus a randomized run against a memory-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_cpu_bus_bridge;

  localparam int unsigned MAX_WAIT = 4;
  localparam int          N_RANDOM = 60;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
  } xact_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cpu_clk_enable;
  logic        cpu_active = 1'b1;
  logic [31:0] cpu_instr_address = 32'h0;
  logic [31:0] cpu_instr_readdata;
  logic [31:0] cpu_data_address = 32'h0;
  logic        cpu_data_read = 1'b0;
  logic        cpu_data_write = 1'b0;
  logic [3:0]  cpu_data_byteenable = 4'h0;
  logic [31:0] cpu_data_writedata = 32'h0;
  logic [31:0] cpu_data_readdata;
  logic [31:0] avm_address;
  logic        avm_read;
  logic        avm_write;
  logic [3:0]  avm_byteenable;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata = 32'h0;
  logic        avm_waitrequest = 1'b1;
  logic        bus_error;

  int checks = 0;
  int errors = 0;

  logic [31:0] slave_mem [logic [31:0]];
  logic [31:0] ref_mem   [logic [31:0]];

  always #5 clk = ~clk;

  mips_cpu_bus_bridge #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk                (clk),
    .reset              (reset),
    .cpu_clk_enable     (cpu_clk_enable),
    .cpu_active         (cpu_active),
    .cpu_instr_address  (cpu_instr_address),
    .cpu_instr_readdata (cpu_instr_readdata),
    .cpu_data_address   (cpu_data_address),
    .cpu_data_read      (cpu_data_read),
    .cpu_data_write     (cpu_data_write),
    .cpu_data_byteenable(cpu_data_byteenable),
    .cpu_data_writedata (cpu_data_writedata),
    .cpu_data_readdata  (cpu_data_readdata),
    .avm_address        (avm_address),
    .avm_read           (avm_read),
    .avm_write          (avm_write),
    .avm_byteenable     (avm_byteenable),
    .avm_writedata      (avm_writedata),
    .avm_readdata       (avm_readdata),
    .avm_waitrequest    (avm_waitrequest),
    .bus_error          (bus_error)
  );

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] slave_word(input logic [31:0] a);
    if (slave_mem.exists(a)) return slave_mem[a];
    return init_word(a);
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return init_word(a);
  endfunction

  function automatic logic [31:0] merge_bytes(input logic [31:0] old, input logic [31:0] wd,
                                              input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  // Advance to just after the next rising edge (the drive point).
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Pulse reset, release it just after an edge; returns at a drive point in FETCH.
  task automatic apply_reset();
    next_cycle();
    reset = 1'b0;
    cpu_active = 1'b1;
    cpu_instr_address = 32'h0;
    cpu_data_address = 32'h0;
    cpu_data_read = 1'b0;
    cpu_data_write = 1'b0;
    cpu_data_byteenable = 4'h0;
    cpu_data_writedata = 32'h0;
    avm_waitrequest = 1'b1;
    avm_readdata = 32'h0;
    next_cycle();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    cpu_active = 1'b1;
    cpu_instr_address = 32'hBFC0_0000;
    avm_waitrequest = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    checks++;
    if ({cpu_clk_enable, avm_read, avm_write} !== 3'b000 || avm_address !== 32'h0 ||
        avm_byteenable !== 4'h0 || avm_writedata !== 32'h0) begin
      errors++;
      $display("FAIL reset_bus got en=%b rd=%b wr=%b addr=%h be=%h wd=%h want all 0",
               cpu_clk_enable, avm_read, avm_write, avm_address, avm_byteenable, avm_writedata);
    end
    checks++;
    if (cpu_instr_readdata !== 32'h0 || cpu_data_readdata !== 32'h0 || bus_error !== 1'b0) begin
      errors++;
      $display("FAIL reset_regs got instr=%h data=%h err=%b want 0 0 0",
               cpu_instr_readdata, cpu_data_readdata, bus_error);
    end
  endtask

  task automatic test_fetch();
    apply_reset();
    cpu_instr_address = 32'hBFC0_0000;
    avm_waitrequest = 1'b0;
    avm_readdata = 32'h2402_0005;
    #1;
    checks++;
    if (avm_read !== 1'b1 || avm_write !== 1'b0 || avm_address !== 32'hBFC0_0000 ||
        avm_byteenable !== 4'hF || cpu_clk_enable !== 1'b0) begin
      errors++;
      $display("FAIL fetch_bus got rd=%b wr=%b addr=%h be=%h en=%b want 1 0 bfc00000 f 0",
               avm_read, avm_write, avm_address, avm_byteenable, cpu_clk_enable);
    end
    next_cycle();
    avm_readdata = 32'hFFFF_FFFF;
    #1;
    checks++;
    if (cpu_clk_enable !== 1'b1 || avm_read !== 1'b0 || avm_write !== 1'b0) begin
      errors++;
      $display("FAIL fetch_step got en=%b rd=%b wr=%b want 1 0 0", cpu_clk_enable, avm_read, avm_write);
    end
    checks++;
    if (cpu_instr_readdata !== 32'h2402_0005) begin
      errors++;
      $display("FAIL fetch_instr got %h want 24020005", cpu_instr_readdata);
    end
    next_cycle();
    cpu_instr_address = 32'hBFC0_0004;
    avm_waitrequest = 1'b1;
    #1;
    checks++;
    if (cpu_clk_enable !== 1'b0 || avm_read !== 1'b1 || avm_address !== 32'hBFC0_0004) begin
      errors++;
      $display("FAIL fetch_next got en=%b rd=%b addr=%h want 0 1 bfc00004",
               cpu_clk_enable, avm_read, avm_address);
    end
  endtask

  task automatic test_load();
    apply_reset();
    cpu_instr_address = 32'h0000_0000;
    cpu_data_read = 1'b1;
    cpu_data_address = 32'h0000_1000;
    avm_waitrequest = 1'b0;
    avm_readdata = 32'h8C02_1000;
    #1;
    checks++;
    if (avm_read !== 1'b1 || avm_address !== 32'h0) begin
      errors++;
      $display("FAIL load_fetch got rd=%b addr=%h want 1 00000000", avm_read, avm_address);
    end
    next_cycle();
    for (int i = 0; i < 4; i++) begin
      avm_waitrequest = (i < 3);
      avm_readdata = (i == 3) ? 32'hDEAD_BEEF : 32'h0BAD_0BAD;
      #1;
      checks++;
      if (avm_read !== 1'b1 || avm_write !== 1'b0 || avm_address !== 32'h0000_1000 ||
          avm_byteenable !== 4'hF || cpu_clk_enable !== 1'b0) begin
        errors++;
        $display("FAIL load_hold cyc=%0d got rd=%b wr=%b addr=%h be=%h en=%b want 1 0 00001000 f 0",
                 i, avm_read, avm_write, avm_address, avm_byteenable, cpu_clk_enable);
      end
      next_cycle();
    end
    #1;
    checks++;
    if (cpu_clk_enable !== 1'b1 || avm_read !== 1'b0 || cpu_data_readdata !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL load_step got en=%b rd=%b data=%h want 1 0 deadbeef",
               cpu_clk_enable, avm_read, cpu_data_readdata);
    end
  endtask

  task automatic test_store();
    apply_reset();
    cpu_instr_address = 32'h0000_0010;
    cpu_data_read = 1'b1;
    cpu_data_address = 32'h0000_2000;
    avm_waitrequest = 1'b0;
    avm_readdata = 32'h8C03_2000;
    next_cycle();
    avm_readdata = 32'h1357_9BDF;
    next_cycle();
    avm_readdata = 32'h0;
    next_cycle();
    cpu_instr_address = 32'h0000_0014;
    cpu_data_read = 1'b1;
    cpu_data_write = 1'b1;
    cpu_data_address = 32'h0000_3000;
    cpu_data_byteenable = 4'b0100;
    cpu_data_writedata = 32'h00AB_0000;
    avm_readdata = 32'hA003_3000;
    next_cycle();
    avm_readdata = 32'hFFFF_FFFF;
    #1;
    checks++;
    if (avm_write !== 1'b1 || avm_read !== 1'b0 || avm_address !== 32'h0000_3000 ||
        avm_byteenable !== 4'b0100 || avm_writedata !== 32'h00AB_0000) begin
      errors++;
      $display("FAIL store_bus got wr=%b rd=%b addr=%h be=%h wd=%h want 1 0 00003000 4 00ab0000",
               avm_write, avm_read, avm_address, avm_byteenable, avm_writedata);
    end
    next_cycle();
    #1;
    checks++;
    if (cpu_clk_enable !== 1'b1 || avm_write !== 1'b0 || avm_read !== 1'b0) begin
      errors++;
      $display("FAIL store_step got en=%b wr=%b rd=%b want 1 0 0", cpu_clk_enable, avm_write, avm_read);
    end
    checks++;
    if (cpu_data_readdata !== 32'h1357_9BDF) begin
      errors++;
      $display("FAIL store_keep got %h want 13579bdf", cpu_data_readdata);
    end
    cpu_data_read = 1'b0;
    cpu_data_write = 1'b0;
  endtask

  task automatic test_timeout();
    int bad;
    apply_reset();
    cpu_instr_address = 32'h0000_0040;
    avm_waitrequest = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (avm_read !== 1'b1 || bus_error !== 1'b0) begin
        errors++;
        $display("FAIL timeout_wait cyc=%0d got rd=%b err=%b want 1 0", i, avm_read, bus_error);
      end
      next_cycle();
    end
    #1;
    checks++;
    if (avm_read !== 1'b0 || bus_error !== 1'b1) begin
      errors++;
      $display("FAIL timeout_trip got rd=%b err=%b want 0 1", avm_read, bus_error);
    end
    bad = 0;
    avm_waitrequest = 1'b0;
    for (int i = 0; i < 30; i++) begin
      next_cycle();
      #1;
      if (cpu_clk_enable || avm_read || avm_write || !bus_error) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL timeout_halted got %0d active cycles want 0", bad);
    end
  endtask

  task automatic test_inactive();
    int bad;
    apply_reset();
    cpu_active = 1'b0;
    cpu_instr_address = 32'h0000_0080;
    avm_waitrequest = 1'b0;
    #1;
    checks++;
    if (avm_read !== 1'b0 || avm_write !== 1'b0 || cpu_clk_enable !== 1'b0) begin
      errors++;
      $display("FAIL inactive_entry got rd=%b wr=%b en=%b want 0 0 0", avm_read, avm_write, cpu_clk_enable);
    end
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      next_cycle();
      if (i == 5) cpu_active = 1'b1;
      #1;
      if (cpu_clk_enable || avm_read || avm_write) bad++;
    end
    checks++;
    if (bad !== 0 || bus_error !== 1'b0) begin
      errors++;
      $display("FAIL inactive_halted got %0d active cycles err=%b want 0 0", bad, bus_error);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    cpu_instr_address = 32'h0000_0400;
    avm_waitrequest = 1'b0;
    avm_readdata = 32'h1111_2222;
    next_cycle();
    next_cycle();
    cpu_instr_address = 32'h0000_0404;
    avm_waitrequest = 1'b1;
    #1;
    checks++;
    if (avm_read !== 1'b1 || avm_address !== 32'h0000_0404 || cpu_instr_readdata !== 32'h1111_2222) begin
      errors++;
      $display("FAIL rstmid_pre got rd=%b addr=%h instr=%h want 1 00000404 11112222",
               avm_read, avm_address, cpu_instr_readdata);
    end
    #1;
    reset = 1'b0;
    #1;
    checks++;
    if (avm_read !== 1'b0 || avm_write !== 1'b0 || avm_address !== 32'h0 || avm_byteenable !== 4'h0 ||
        cpu_clk_enable !== 1'b0 || cpu_instr_readdata !== 32'h0 || cpu_data_readdata !== 32'h0 ||
        bus_error !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_drop got rd=%b wr=%b addr=%h be=%h en=%b instr=%h data=%h err=%b want all 0",
               avm_read, avm_write, avm_address, avm_byteenable, cpu_clk_enable,
               cpu_instr_readdata, cpu_data_readdata, bus_error);
    end
    next_cycle();
    next_cycle();
    reset = 1'b1;
    cpu_instr_address = 32'h0000_0800;
    avm_waitrequest = 1'b0;
    avm_readdata = 32'h3333_4444;
    #1;
    checks++;
    if (avm_read !== 1'b1 || avm_address !== 32'h0000_0800) begin
      errors++;
      $display("FAIL rstmid_restart got rd=%b addr=%h want 1 00000800", avm_read, avm_address);
    end
    next_cycle();
    #1;
    checks++;
    if (cpu_clk_enable !== 1'b1 || cpu_instr_readdata !== 32'h3333_4444) begin
      errors++;
      $display("FAIL rstmid_step got en=%b instr=%h want 1 33334444", cpu_clk_enable, cpu_instr_readdata);
    end
  endtask

  // Random next instruction for the core model.
  task automatic gen_instr(output logic [31:0] pc, output logic rd, output logic wr,
                           output logic [31:0] daddr, output logic [3:0] be, output logic [31:0] wd);
    int sel;
    sel = $urandom_range(0, 3);
    pc = 32'hBFC0_0000 + (32'($urandom_range(0, 255)) << 2);
    rd = (sel == 1) || (sel == 3);
    wr = (sel == 2) || (sel == 3);
    daddr = 32'h0000_0100 + (32'($urandom_range(0, 7)) << 2);
    be = 4'($urandom_range(1, 15));
    wd = $urandom();
  endtask

  task automatic test_random();
    xact_t       obs_q[$];
    xact_t       exp_q[$];
    xact_t       x;
    logic [31:0] pc, daddr, wd, exp_instr, exp_data;
    logic [3:0]  be;
    logic        rd, wr, pending, prev_stall;
    logic [69:0] prev_bus, cur_bus;
    int          k, cyc, waits, wait_left, budget, exp_cycles;

    apply_reset();
    slave_mem.delete();
    ref_mem.delete();
    exp_data = 32'h0;
    prev_bus = '0;
    k = 0; cyc = 0; waits = 0; budget = 0;
    prev_stall = 1'b0;
    pending = 1'b1;
    wait_left = $urandom_range(0, 3);
    gen_instr(pc, rd, wr, daddr, be, wd);
    while (k < N_RANDOM && budget < 4000) begin
      if (pending) begin
        cpu_instr_address = pc;
        cpu_data_read = rd;
        cpu_data_write = wr;
        cpu_data_address = daddr;
        cpu_data_byteenable = be;
        cpu_data_writedata = wd;
        pending = 1'b0;
      end
      #1;
      if (avm_read || avm_write) avm_waitrequest = (wait_left != 0);
      else avm_waitrequest = 1'($urandom_range(0, 1));
      avm_readdata = avm_waitrequest ? $urandom() : slave_word(avm_address);
      #1;
      cyc++;
      cur_bus = {avm_read, avm_write, avm_address, avm_byteenable, avm_writedata};
      if (prev_stall) begin
        checks++;
        if (cur_bus !== prev_bus) begin
          errors++;
          $display("FAIL rnd_stable k=%0d got %h want %h", k, cur_bus, prev_bus);
        end
      end
      checks++;
      if ((cpu_clk_enable & (avm_read | avm_write)) !== 1'b0) begin
        errors++;
        $display("FAIL rnd_overlap k=%0d got en=%b rd=%b wr=%b want no overlap",
                 k, cpu_clk_enable, avm_read, avm_write);
      end
      if (avm_read || avm_write) begin
        if (avm_waitrequest) begin
          waits++;
          wait_left--;
          prev_stall = 1'b1;
          prev_bus = cur_bus;
        end else begin
          x.wr = avm_write;
          x.addr = avm_address;
          x.be = avm_byteenable;
          x.wd = avm_write ? avm_writedata : 32'h0;
          obs_q.push_back(x);
          if (avm_write) slave_mem[avm_address] = merge_bytes(slave_word(avm_address), avm_writedata, avm_byteenable);
          wait_left = $urandom_range(0, 3);
          prev_stall = 1'b0;
        end
      end else begin
        prev_stall = 1'b0;
      end
      if (cpu_clk_enable) begin
        exp_instr = ref_word(pc);
        exp_q.delete();
        x.wr = 1'b0; x.addr = pc; x.be = 4'hF; x.wd = 32'h0;
        exp_q.push_back(x);
        if (wr) begin
          x.wr = 1'b1; x.addr = daddr; x.be = be; x.wd = wd;
          exp_q.push_back(x);
          ref_mem[daddr] = merge_bytes(ref_word(daddr), wd, be);
        end else if (rd) begin
          x.wr = 1'b0; x.addr = daddr; x.be = 4'hF; x.wd = 32'h0;
          exp_q.push_back(x);
          exp_data = ref_word(daddr);
        end
        exp_cycles = 2 + ((rd || wr) ? 1 : 0) + waits;
        checks++;
        if (cpu_instr_readdata !== exp_instr) begin
          errors++;
          $display("FAIL rnd_instr k=%0d got %h want %h", k, cpu_instr_readdata, exp_instr);
        end
        checks++;
        if (cpu_data_readdata !== exp_data) begin
          errors++;
          $display("FAIL rnd_data k=%0d got %h want %h", k, cpu_data_readdata, exp_data);
        end
        checks++;
        if (cyc !== exp_cycles) begin
          errors++;
          $display("FAIL rnd_latency k=%0d got %0d want %0d", k, cyc, exp_cycles);
        end
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
          errors++;
          $display("FAIL rnd_count k=%0d got %0d want %0d", k, obs_q.size(), exp_q.size());
        end else begin
          for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
              errors++;
              $display("FAIL rnd_xact k=%0d idx=%0d got %h want %h", k, i, obs_q[i], exp_q[i]);
            end
          end
        end
        obs_q.delete();
        cyc = 0;
        waits = 0;
        k++;
        gen_instr(pc, rd, wr, daddr, be, wd);
        pending = 1'b1;
      end
      next_cycle();
      budget++;
    end
    checks++;
    if (k < N_RANDOM) begin
      errors++;
      $display("FAIL rnd_progress got %0d steps want %0d", k, N_RANDOM);
    end
    checks++;
    if (bus_error !== 1'b0) begin
      errors++;
      $display("FAIL rnd_error got %b want 0", bus_error);
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_load();
    test_store();
    test_timeout();
    test_inactive();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
